uart_tx: RTL and testbench



---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_baud_tick.sv | 29 ++
 rtl/uart_tx.sv | 130 +++++++++++++
 tb/tb_uart_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the serial transmitter and receiver: state encoding
// and parity-mode constants.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_baud_tick.sv
// Baud counter: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick_o in
// the last cycle of every bit period. Held at zero while disabled.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !en_i) begin
      cnt_q <= '0;
    end else if (cnt_q == LAST) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/uart_tx.sv
// Serial transmitter: one byte per valid/ready handshake, sent as
// start / data LSB-first / optional parity / stop with fully registered outputs.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o
);

  if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 || DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_param
    $error("uart_tx: illegal parameter value");
  end

  localparam int BW = $clog2(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  uart_state_t          state_q, state_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q;
  logic                 tick;
  logic                 accept;
  logic                 tx_d, ready_d, busy_d;
  logic                 tx_q, ready_q, busy_q;

  assign accept = valid_i && ready_q;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .en_i  (state_q != ST_IDLE),
    .tick_o(tick)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    shreg_d   = shreg_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_START;
          shreg_d = data_i;
        end
      end
      ST_START: begin
        if (tick) state_d = ST_DATA;
      end
      ST_DATA: begin
        bit_cnt_d = bit_cnt_q;
        if (tick) begin
          shreg_d = shreg_q >> 1;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            state_d   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      ST_PARITY: begin
        if (tick) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (tick) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shreg_d[0];
      ST_PARITY: tx_d = par_q;
      default:   tx_d = 1'b1;
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = !ready_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
    end
  end

  // Parity is fixed at the handshake; later data_i activity cannot disturb it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      par_q <= (^data_i) ^ (PARITY == PAR_ODD);
    end
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: three instances (no parity, even, odd) with
// CLKS_PER_BIT = 4 and DATA_BITS = 8, checked against a per-bit frame model.
module tb_uart_tx;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data;
  logic       valid [3];
  logic       tx    [3];
  logic       rdy   [3];
  logic       bsy   [3];

  int   checks = 0;
  int   errors = 0;
  logic cap_tx  [0:63];
  logic cap_rdy [0:63];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0)) dut0 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid[0]),
    .ready_o(rdy[0]), .tx_o(tx[0]), .busy_o(bsy[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid[1]),
    .ready_o(rdy[1]), .tx_o(tx[1]), .busy_o(bsy[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2)) dut2 (
    .clk_i(clk), .rst_i(rst), .data_i(data), .valid_i(valid[2]),
    .ready_o(rdy[2]), .tx_o(tx[2]), .busy_o(bsy[2]));

  // Expected line level in bit period p of a frame carrying b.
  function automatic logic exp_bit(input logic [7:0] b, input int par, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
    if (p == 9 && par != 0) return (^b) ^ (par == 2);
    return 1'b1;
  endfunction

  // Records n cycles of line and ready, starting in the current cycle.
  task automatic capture(input int d, input int n);
    for (int c = 0; c < n; c++) begin
      cap_tx[c]  = tx[d];
      cap_rdy[c] = rdy[d];
      @(posedge clk); #1;
    end
  endtask

  // Called #1 after an edge with the instance idle; returns in frame cycle 1.
  task automatic send(input int d, input logic [7:0] b);
    data     = b;
    valid[d] = 1'b1;
    @(posedge clk); #1;
    valid[d] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    data = 8'hFF;
    for (int i = 0; i < 3; i++) valid[i] = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      for (int d = 0; d < 3; d++) begin
        checks++;
        if (tx[d] !== 1'b1 || rdy[d] !== 1'b1 || bsy[d] !== 1'b0) begin
          errors++;
          $display("FAIL reset dut%0d cyc%0d got tx=%b rdy=%b busy=%b want 1 1 0", d, k, tx[d], rdy[d], bsy[d]);
        end
      end
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    @(posedge clk); #1;
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (tx[d] !== 1'b1 || rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL reset_idle dut%0d got tx=%b rdy=%b want 1 1", d, tx[d], rdy[d]);
      end
    end
  endtask

  task automatic test_single();
    send(0, 8'hA5);
    checks++;
    if (rdy[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL single_busy got rdy=%b busy=%b want 0 1", rdy[0], bsy[0]);
    end
    capture(0, 40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(8'hA5, 0, c / CPB) || cap_rdy[c] !== 1'b0) begin
        errors++;
        $display("FAIL single_frame cyc%0d got tx=%b rdy=%b want tx=%b rdy=0",
                 c + 1, cap_tx[c], cap_rdy[c], exp_bit(8'hA5, 0, c / CPB));
      end
    end
    checks++;
    if (rdy[0] !== 1'b1 || tx[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_done got rdy=%b tx=%b busy=%b want 1 1 0", rdy[0], tx[0], bsy[0]);
    end
  endtask

  task automatic test_parity();
    for (int d = 1; d < 3; d++) begin
      send(d, 8'h07);
      capture(d, 44);
      for (int c = 0; c < 44; c++) begin
        checks++;
        if (cap_tx[c] !== exp_bit(8'h07, d, c / CPB) || cap_rdy[c] !== 1'b0) begin
          errors++;
          $display("FAIL parity%0d_frame cyc%0d got tx=%b rdy=%b want tx=%b rdy=0",
                   d, c + 1, cap_tx[c], cap_rdy[c], exp_bit(8'h07, d, c / CPB));
        end
      end
      checks++;
      if (cap_tx[36] !== ((d == 1) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL parity%0d_bit got %b want %b", d, cap_tx[36], (d == 1) ? 1'b1 : 1'b0);
      end
      checks++;
      if (rdy[d] !== 1'b1) begin
        errors++;
        $display("FAIL parity%0d_done got rdy=%b want 1", d, rdy[d]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int ready_cycles;
    data     = 8'h55;
    valid[0] = 1'b1;
    @(posedge clk); #1;
    data = 8'hAA;
    capture(0, 41);
    valid[0] = 1'b0;
    ready_cycles = 0;
    for (int c = 0; c < 41; c++) if (cap_rdy[c] === 1'b1) ready_cycles++;
    checks++;
    if (ready_cycles != 1 || cap_rdy[40] !== 1'b1 || cap_tx[40] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_gap got ready_cycles=%0d rdy41=%b tx41=%b want 1 1 1",
               ready_cycles, cap_rdy[40], cap_tx[40]);
    end
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(8'h55, 0, c / CPB)) begin
        errors++;
        $display("FAIL b2b_first cyc%0d got %b want %b", c + 1, cap_tx[c], exp_bit(8'h55, 0, c / CPB));
      end
    end
    checks++;
    if (rdy[0] !== 1'b0 || tx[0] !== 1'b0) begin
      errors++;
      $display("FAIL b2b_second_start got rdy=%b tx=%b want 0 0", rdy[0], tx[0]);
    end
    capture(0, 40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(8'hAA, 0, c / CPB)) begin
        errors++;
        $display("FAIL b2b_second cyc%0d got %b want %b", c + 1, cap_tx[c], exp_bit(8'hAA, 0, c / CPB));
      end
    end
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done got rdy=%b want 1", rdy[0]);
    end
  endtask

  task automatic test_ignored_inputs();
    send(0, 8'h3C);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (tx[0] !== exp_bit(8'h3C, 0, c / CPB) || rdy[0] !== 1'b0) begin
        errors++;
        $display("FAIL ignored_frame cyc%0d got tx=%b rdy=%b want tx=%b rdy=0",
                 c + 1, tx[0], rdy[0], exp_bit(8'h3C, 0, c / CPB));
      end
      data     = ~data ^ 8'(c);
      valid[0] = (c < 39) ? ~valid[0] : 1'b0;
      @(posedge clk); #1;
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rdy[0] !== 1'b1 || tx[0] !== 1'b1) begin
        errors++;
        $display("FAIL ignored_idle cyc%0d got rdy=%b tx=%b want 1 1", 41 + k, rdy[0], tx[0]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_frame();
    send(0, 8'hF0);
    capture(0, 18);
    checks++;
    if (tx[0] !== 1'b0 || bsy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_before got tx=%b busy=%b want 0 1", tx[0], bsy[0]);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (tx[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after got tx=%b rdy=%b busy=%b want 1 1 0", tx[0], rdy[0], bsy[0]);
    end
    @(posedge clk); #1;
    checks++;
    if (tx[0] !== 1'b1 || rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_idle got tx=%b rdy=%b want 1 1", tx[0], rdy[0]);
    end
    send(0, 8'h81);
    capture(0, 40);
    for (int c = 0; c < 40; c++) begin
      checks++;
      if (cap_tx[c] !== exp_bit(8'h81, 0, c / CPB)) begin
        errors++;
        $display("FAIL midrst_next cyc%0d got %b want %b", c + 1, cap_tx[c], exp_bit(8'h81, 0, c / CPB));
      end
    end
    checks++;
    if (rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL midrst_done got rdy=%b want 1", rdy[0]);
    end
  endtask

  initial begin
    rst  = 1'b1;
    data = '0;
    for (int i = 0; i < 3; i++) valid[i] = 1'b0;
    test_reset();
    test_single();
    test_parity();
    test_back_to_back();
    test_ignored_inputs();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
